// File: rtl/ex_mem_pipe.sv
// rtl/ex_mem_pipe.sv - EX/MEM pipeline register with optional skid slot and ready/valid handshake
module ex_mem_pipe #(
  parameter int XLEN        = 32,
  parameter int RADDR_W     = 5,
  parameter int SKID        = 1,
  parameter int X0_SUPPRESS = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               RegW_enable_E,
  input  logic               Mem_Write_E,
  input  logic               Mem_Read_E,
  input  logic               Result_src_E,
  input  logic [XLEN-1:0]    ALU_result_E,
  input  logic [XLEN-1:0]    Write_Data_E,
  input  logic [RADDR_W-1:0] RDadd_E,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               RegW_enable_M,
  output logic               Mem_Write_M,
  output logic               Mem_Read_M,
  output logic               Result_src_M,
  output logic [XLEN-1:0]    ALU_result_M,
  output logic [XLEN-1:0]    Write_Data_M,
  output logic [RADDR_W-1:0] RDadd_M,
  output logic [1:0]         occupancy
);

  // One held instruction: {regw, memw, memr, rsrc, alu, wdata, rd}
  localparam int EW = 4 + 2 * XLEN + RADDR_W;

  logic [EW-1:0] in_ent;
  logic [EW-1:0] o_ent, o_ent_n;
  logic [EW-1:0] s_ent, s_ent_n;
  logic          o_valid, o_valid_n;
  logic          s_valid, s_valid_n;
  logic          rdy_r;
  logic [1:0]    occ_r;
  logic          regw_store;
  logic          accept;
  logic          consume;
  logic          o_regw, o_memw, o_memr;

  // Writes to x0 are architecturally dead, so drop the enable at capture time
  assign regw_store = RegW_enable_E && !((X0_SUPPRESS != 0) && (RDadd_E == '0));
  assign in_ent     = {regw_store, Mem_Write_E, Mem_Read_E, Result_src_E,
                       ALU_result_E, Write_Data_E, RDadd_E};

  // The skid variant exposes a registered ready; the single-entry variant passes
  // downstream ready straight through. Both are held low while in reset.
  assign in_ready = !rst && ((SKID != 0) ? rdy_r : (!o_valid || out_ready));
  assign accept   = in_valid && in_ready;
  assign consume  = o_valid && out_ready;

  // Next-state for output slot O and skid slot S; flush empties both and drops the input
  always_comb begin
    o_valid_n = o_valid;
    s_valid_n = s_valid;
    o_ent_n   = o_ent;
    s_ent_n   = s_ent;
    if (flush) begin
      o_valid_n = 1'b0;
      s_valid_n = 1'b0;
    end else if (!o_valid || consume) begin
      if (s_valid) begin
        o_ent_n   = s_ent;
        o_valid_n = 1'b1;
        s_valid_n = 1'b0;
      end else if (accept) begin
        o_ent_n   = in_ent;
        o_valid_n = 1'b1;
      end else begin
        o_valid_n = 1'b0;
      end
    end else if (accept && (SKID != 0)) begin
      s_ent_n   = in_ent;
      s_valid_n = 1'b1;
    end
  end

  // State registers; ready and occupancy are registered from the next-state values
  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid <= 1'b0;
      s_valid <= 1'b0;
      o_ent   <= '0;
      s_ent   <= '0;
      rdy_r   <= 1'b1;
      occ_r   <= 2'd0;
    end else begin
      o_valid <= o_valid_n;
      s_valid <= s_valid_n;
      o_ent   <= o_ent_n;
      s_ent   <= s_ent_n;
      rdy_r   <= !s_valid_n;
      occ_r   <= {1'b0, o_valid_n} + {1'b0, s_valid_n};
    end
  end

  assign {o_regw, o_memw, o_memr, Result_src_M, ALU_result_M, Write_Data_M, RDadd_M} = o_ent;

  // Side-effecting controls are masked during bubbles; data fields keep their last value
  assign RegW_enable_M = o_valid && o_regw;
  assign Mem_Write_M   = o_valid && o_memw;
  assign Mem_Read_M    = o_valid && o_memr;
  assign out_valid     = o_valid;
  assign occupancy     = occ_r;

endmodule

// File: tb/tb_ex_mem_pipe.sv
// tb/tb_ex_mem_pipe.sv - randomized and directed bench for ex_mem_pipe against a FIFO reference model
module tb_ex_mem_pipe;

  typedef struct packed {
    logic        regw;
    logic        memw;
    logic        memr;
    logic        rsrc;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic        regw_e, memw_e, memr_e, rsrc_e;
  logic [31:0] alu_e, wd_e;
  logic [4:0]  rd_e;

  logic        a_in_ready, a_out_valid, a_regw, a_memw, a_memr, a_rsrc;
  logic [31:0] a_alu, a_wd;
  logic [4:0]  a_rd;
  logic [1:0]  a_occ;
  logic        b_in_ready, b_out_valid, b_regw, b_memw, b_memr, b_rsrc;
  logic [31:0] b_alu, b_wd;
  logic [4:0]  b_rd;
  logic [1:0]  b_occ;

  int checks;
  int failures;
  bit armed;

  // Reference model per instance (0: skid + x0 suppress, 1: single entry, no suppress)
  ent_t fifo [2][2];
  int   cnt [2];
  bit   rdy [2];
  ent_t lastf [2];

  ex_mem_pipe #(.XLEN(32), .RADDR_W(5), .SKID(1), .X0_SUPPRESS(1)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
    .RegW_enable_E(regw_e), .Mem_Write_E(memw_e), .Mem_Read_E(memr_e), .Result_src_E(rsrc_e),
    .ALU_result_E(alu_e), .Write_Data_E(wd_e), .RDadd_E(rd_e),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .RegW_enable_M(a_regw), .Mem_Write_M(a_memw), .Mem_Read_M(a_memr), .Result_src_M(a_rsrc),
    .ALU_result_M(a_alu), .Write_Data_M(a_wd), .RDadd_M(a_rd), .occupancy(a_occ)
  );

  ex_mem_pipe #(.XLEN(32), .RADDR_W(5), .SKID(0), .X0_SUPPRESS(0)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
    .RegW_enable_E(regw_e), .Mem_Write_E(memw_e), .Mem_Read_E(memr_e), .Result_src_E(rsrc_e),
    .ALU_result_E(alu_e), .Write_Data_E(wd_e), .RDadd_E(rd_e),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .RegW_enable_M(b_regw), .Mem_Write_M(b_memw), .Mem_Read_M(b_memr), .Result_src_M(b_rsrc),
    .ALU_result_M(b_alu), .Write_Data_M(b_wd), .RDadd_M(b_rd), .occupancy(b_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $fatal(1, "FAIL watchdog: simulation did not finish in time");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ent_t exp_out(input int i);
    ent_t x;
    x = lastf[i];
    if (cnt[i] == 0) begin
      x.regw = 1'b0;
      x.memw = 1'b0;
      x.memr = 1'b0;
    end
    return x;
  endfunction

  // One clock: drive at negedge, compare against the model, then advance the model at posedge
  task automatic cycle(input bit iv, input bit ordy, input bit fl, input bit rs,
                       input logic [31:0] alu, input int rg, input int rdi, output bit acc_a);
    ent_t e, p;
    bit   er [2];
    @(negedge clk);
    e.regw = (rg < 0) ? 1'($urandom % 2) : 1'(rg);
    e.memw = 1'($urandom % 2);
    e.memr = 1'($urandom % 2);
    e.rsrc = 1'($urandom % 2);
    e.alu  = alu;
    e.wd   = $urandom;
    e.rd   = (rdi < 0) ? 5'($urandom % 32) : 5'(rdi);
    in_valid = iv; out_ready = ordy; flush = fl; rst = rs;
    regw_e = e.regw; memw_e = e.memw; memr_e = e.memr; rsrc_e = e.rsrc;
    alu_e = e.alu; wd_e = e.wd; rd_e = e.rd;
    #1;
    er[0] = !rs && rdy[0];
    er[1] = !rs && (cnt[1] == 0 || ordy);
    if (armed) begin
      chk("a_out_valid", a_out_valid, cnt[0] > 0);
      chk("a_in_ready", a_in_ready, er[0]);
      chk("a_occupancy", a_occ, cnt[0]);
      chk("a_fields", {a_regw, a_memw, a_memr, a_rsrc, a_alu, a_wd, a_rd}, exp_out(0));
      chk("b_out_valid", b_out_valid, cnt[1] > 0);
      chk("b_in_ready", b_in_ready, er[1]);
      chk("b_occupancy", b_occ, cnt[1]);
      chk("b_fields", {b_regw, b_memw, b_memr, b_rsrc, b_alu, b_wd, b_rd}, exp_out(1));
    end
    @(posedge clk);
    acc_a = iv && er[0];
    for (int i = 0; i < 2; i++) begin
      if (rs) begin
        cnt[i] = 0; lastf[i] = '0; rdy[i] = 1'b1;
      end else if (fl) begin
        cnt[i] = 0; rdy[i] = 1'b1;
      end else begin
        if (cnt[i] > 0 && ordy) begin
          fifo[i][0] = fifo[i][1];
          cnt[i]--;
        end
        if (iv && er[i]) begin
          p = e;
          if (i == 0 && e.rd == 5'd0) p.regw = 1'b0;
          fifo[i][cnt[i]] = p;
          cnt[i]++;
        end
        rdy[i] = (cnt[i] < 2);
        if (cnt[i] > 0) lastf[i] = fifo[i][0];
      end
    end
    armed = 1'b1;
  endtask

  initial begin
    bit acc;
    int n;
    checks = 0; failures = 0; armed = 1'b0;
    cnt[0] = 0; cnt[1] = 0; rdy[0] = 1'b0; rdy[1] = 1'b0;
    lastf[0] = '0; lastf[1] = '0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    regw_e = 0; memw_e = 0; memr_e = 0; rsrc_e = 0; alu_e = 0; wd_e = 0; rd_e = 0;

    // Reset
    cycle(0, 0, 0, 1, 32'h0, -1, -1, acc);
    cycle(0, 0, 0, 1, 32'h0, -1, -1, acc);

    // Streaming 1..8
    for (int k = 1; k <= 8; k++) begin
      cycle(1, 1, 0, 0, 32'(k), -1, -1, acc);
      chk("stream_accept", acc, 1'b1);
    end
    cycle(0, 1, 0, 0, 32'h0, -1, -1, acc);
    cycle(0, 1, 0, 0, 32'h0, -1, -1, acc);

    // Backpressure: A, B fill both slots, C waits upstream
    cycle(1, 0, 0, 0, 32'hA, -1, -1, acc);
    cycle(1, 0, 0, 0, 32'hB, -1, -1, acc);
    #1;
    chk("bp_occupancy", a_occ, 2'd2);
    chk("bp_in_ready", a_in_ready, 1'b0);
    cycle(1, 0, 0, 0, 32'hC, -1, -1, acc);
    chk("bp_c_held", acc, 1'b0);
    n = 0;
    do begin
      cycle(1, 1, 0, 0, 32'hC, -1, -1, acc);
      n++;
    end while (!acc && n < 10);
    chk("bp_c_taken", acc, 1'b1);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 32'h0, -1, -1, acc);

    // Flush with both slots full and a live input
    cycle(1, 0, 0, 0, 32'h11, -1, -1, acc);
    cycle(1, 0, 0, 0, 32'h12, -1, -1, acc);
    cycle(1, 0, 1, 0, 32'hF1, -1, -1, acc);
    #1;
    chk("flush_out_valid", a_out_valid, 1'b0);
    chk("flush_occupancy", a_occ, 2'd0);
    chk("flush_mem_write", a_memw, 1'b0);
    chk("flush_in_ready", a_in_ready, 1'b1);
    cycle(0, 1, 0, 0, 32'h0, -1, -1, acc);
    cycle(0, 1, 0, 0, 32'h0, -1, -1, acc);

    // x0 destination handling
    cycle(1, 1, 0, 0, 32'h20, 1, 0, acc);
    #1;
    chk("x0_suppressed", a_regw, 1'b0);
    chk("x0_kept", b_regw, 1'b1);
    cycle(1, 1, 0, 0, 32'h21, 1, 5, acc);
    #1;
    chk("x5_a_regw", a_regw, 1'b1);
    chk("x5_b_regw", b_regw, 1'b1);
    cycle(0, 1, 0, 0, 32'h0, -1, -1, acc);

    // Single-entry variant: ready follows out_ready combinationally
    cycle(1, 0, 0, 0, 32'h30, -1, -1, acc);
    cycle(1, 0, 0, 0, 32'h31, -1, -1, acc);
    cycle(1, 1, 0, 0, 32'h32, -1, -1, acc);
    #1;
    chk("s0_replaced", b_alu, 32'h32);
    chk("s0_valid", b_out_valid, 1'b1);
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 32'h0, -1, -1, acc);

    // Random traffic with occasional flush and reset
    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom % 2), ($urandom % 4) != 0, ($urandom % 32) == 0,
            ($urandom % 64) == 0, $urandom, -1, -1, acc);
    end
    for (int k = 0; k < 3; k++) cycle(0, 1, 0, 0, 32'h0, -1, -1, acc);

    // Reset pulse with two entries held
    cycle(1, 0, 0, 0, 32'h41, -1, -1, acc);
    cycle(1, 0, 0, 0, 32'h42, -1, -1, acc);
    #1;
    chk("prerst_occupancy", a_occ, 2'd2);
    cycle(1, 0, 0, 1, 32'h43, -1, -1, acc);
    #1;
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_occupancy", a_occ, 2'd0);
    chk("rst_alu", a_alu, 32'h0);
    chk("rst_wd", a_wd, 32'h0);
    cycle(0, 1, 0, 0, 32'h0, -1, -1, acc);
    cycle(0, 1, 0, 0, 32'h0, -1, -1, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe.md
EX_MEM_PIPE -- requirements
Module: ex_mem_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, data path width of ALU_result and Write_Data.
REQ-002 SHALL have parameter RADDR_W, default 5, destination register address width.
REQ-003 SHALL have parameter SKID, default 1; 1 = two-entry buffering with registered in_ready, 0 = single entry with combinational in_ready.
REQ-004 SHALL have parameter X0_SUPPRESS, default 1; 1 = RegW_enable forced 0 for destination address 0.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 flush  input  1  discard all held entries and the current input.
REQ-008 in_valid  input  1  EX stage presents an instruction.
REQ-009 in_ready  output  1  block accepts the input this cycle.
REQ-010 RegW_enable_E, Mem_Write_E, Mem_Read_E, Result_src_E  input  1 each  EX control bits.
REQ-011 ALU_result_E, Write_Data_E  input  XLEN each  EX data.
REQ-012 RDadd_E  input  RADDR_W  EX destination register.
REQ-013 out_valid  output  1  MEM-side entry valid.
REQ-014 out_ready  input  1  MEM stage consumes the entry.
REQ-015 RegW_enable_M, Mem_Write_M, Mem_Read_M, Result_src_M, ALU_result_M, Write_Data_M, RDadd_M  output  widths as E counterparts  registered MEM-side fields.
REQ-016 occupancy  output  2  number of held entries, 0..2 (0..1 when SKID=0).

Function
REQ-017 Accept: input captured when in_valid && in_ready at a rising edge; Consume: output entry retired when out_valid && out_ready.
REQ-018 Latency: accepted instruction SHALL appear on _M outputs with out_valid=1 the cycle after acceptance when the output slot is empty or being consumed that cycle.
REQ-019 Ordering: entries SHALL leave in acceptance order; no entry dropped or duplicated except by flush/rst.
REQ-020 SKID=1: entries held in output slot (O) and skid slot (S); in_ready SHALL be a register equal to !S_valid.
REQ-021 SKID=1, O empty, accept -> input to O.
REQ-022 SKID=1, O full and consumed, S empty, accept -> input to O (replaces retired entry).
REQ-023 SKID=1, O full and not consumed, accept -> input to S; in_ready 0 the following cycle.
REQ-024 SKID=1, O and S full, consume -> S moves to O; S empty, in_ready 1 the following cycle.
REQ-025 SKID=0: in_ready SHALL equal !out_valid || out_ready combinationally; S absent; occupancy max 1.
REQ-026 Bubble gating: when out_valid=0, RegW_enable_M, Mem_Write_M, Mem_Read_M SHALL be 0; other _M fields hold last value.
REQ-027 X0_SUPPRESS=1: an entry with RDadd_E=0 SHALL be stored with RegW_enable=0.
REQ-028 Flush: at the edge with flush=1, O and S SHALL be emptied, the input that cycle discarded; next cycle out_valid=0, occupancy=0, in_ready=1.
REQ-029 flush and rst SHALL override accept and consume in the same cycle.
REQ-030 occupancy SHALL equal O_valid + S_valid, registered.

Reset
REQ-031 On rst at a rising edge: out_valid=0, occupancy=0, all _M outputs 0, S cleared.
REQ-032 in_ready SHALL be 0 while rst is high and 1 the first cycle after rst deasserts.
REQ-033 rst asserted mid-operation SHALL discard all held entries with no _M output of them afterwards.

Verification
REQ-034 Streaming: in_valid=1, out_ready=1, 8 back-to-back instrs ALU_result_E=1..8 -> out_valid from cycle 1, ALU_result_M=1..8 in order, in_ready constant 1, occupancy 1.
REQ-035 Backpressure (SKID=1): out_ready=0, send A=0xA, B=0xB -> occupancy 2, in_ready 0, C held upstream; out_ready=1 -> A, B, C emerge in order, in_ready returns 1 one cycle after S drains.
REQ-036 Flush with occupancy 2, in_valid=1 -> next cycle out_valid=0, occupancy=0, Mem_Write_M=0, flushed-cycle input never appears.
REQ-037 X0: RegW_enable_E=1, RDadd_E=0 -> RegW_enable_M=0 (X0_SUPPRESS=1), =1 (X0_SUPPRESS=0); RDadd_E=5 -> RegW_enable_M=1.
REQ-038 SKID=0: out_ready=0 with out_valid=1 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle, new entry replaces old next edge.
REQ-039 rst pulse with occupancy 2 -> all _M outputs 0, out_valid 0, in_ready 0 during rst, 1 the cycle after.
